// File: rtl/load_resp_stage_if.sv
// Bundle for the load-response stage: execute-side inputs, RAM read data and writeback outputs.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface load_resp_stage_if;
  logic        in_valid;
  logic        in_allow_in;
  logic [5:0]  in_ex;
  logic [31:0] in_pc;
  logic [31:0] in_ctrl_info;
  logic [31:0] in_ctrl_info2;
  logic [4:0]  in_dest;
  logic [31:0] in_mem_value;
  logic [1:0]  in_offset;
  logic [31:0] data_ram_dout;
  logic        out_allow;
  logic        out_valid;
  logic [5:0]  out_ex;
  logic [31:0] out_pc;
  logic [4:0]  out_dest;
  logic [31:0] out_ctrl_info;
  logic [31:0] out_ctrl_info2;
  logic [31:0] wb_value;
  logic        data_finish;

  modport slave (
    input  in_valid, in_ex, in_pc, in_ctrl_info, in_ctrl_info2, in_dest,
           in_mem_value, in_offset, data_ram_dout, out_allow,
    output in_allow_in, out_valid, out_ex, out_pc, out_dest, out_ctrl_info,
           out_ctrl_info2, wb_value, data_finish
  );

  modport master (
    output in_valid, in_ex, in_pc, in_ctrl_info, in_ctrl_info2, in_dest,
           in_mem_value, in_offset, data_ram_dout, out_allow,
    input  in_allow_in, out_valid, out_ex, out_pc, out_dest, out_ctrl_info,
           out_ctrl_info2, wb_value, data_finish
  );
endinterface

// File: rtl/load_resp_stage.sv
// Load-response pipeline stage: one-cycle occupancy, extracts LW/LB/LBU/LH/LHU data from RAM read data.
// Backpressure: holds the instruction while out_allow is low and keeps the first-cycle RAM word in a hold register.
module load_resp_stage (
  input  logic             clk,
  input  logic             resetn,
  load_resp_stage_if.slave bus
);
  logic        r_valid;
  logic        r_hold_vld;
  logic [31:0] r_dout_hold;
  logic [5:0]  r_ex;
  logic [31:0] r_pc;
  logic [31:0] r_ctrl;
  logic [31:0] r_ctrl2;
  logic [4:0]  r_dest;
  logic [31:0] r_mem_value;
  logic [1:0]  r_offset;

  logic        w_allow_in;
  logic        w_capture;
  logic        w_reg_we;
  logic        w_load_op;
  logic [4:0]  w_load_type;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_allow_in  = !r_valid || bus.out_allow;
  assign w_capture   = bus.in_valid && w_allow_in;
  assign w_reg_we    = r_ctrl[27];
  assign w_load_op   = r_ctrl[11];
  assign w_load_type = r_ctrl[10:6];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_ex        <= '0;
      r_pc        <= '0;
      r_ctrl      <= '0;
      r_ctrl2     <= '0;
      r_dest      <= '0;
      r_mem_value <= '0;
      r_offset    <= '0;
    end else begin
      if (w_allow_in) begin
        r_valid <= bus.in_valid;
      end
      if (w_capture) begin
        r_ex        <= bus.in_ex;
        r_pc        <= bus.in_pc;
        r_ctrl      <= bus.in_ctrl_info;
        r_ctrl2     <= bus.in_ctrl_info2;
        r_dest      <= bus.in_dest;
        r_mem_value <= bus.in_mem_value;
        r_offset    <= bus.in_offset;
      end
    end
  end

  // The RAM word is only valid on the first occupancy cycle, so a stall must freeze it here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold_vld  <= 1'b0;
      r_dout_hold <= '0;
    end else if (w_allow_in) begin
      r_hold_vld <= 1'b0;
    end else if (!r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_dout_hold <= bus.data_ram_dout;
    end
  end

  assign w_word = r_hold_vld ? r_dout_hold : bus.data_ram_dout;
  assign w_half = r_offset[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_offset)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  // Anything other than a single load-type bit yields zero rather than a guess.
  always_comb begin
    w_load_data = '0;
    case (w_load_type)
      5'b00001: w_load_data = w_word;
      5'b00010: w_load_data = {{24{w_byte[7]}}, w_byte};
      5'b00100: w_load_data = {24'd0, w_byte};
      5'b01000: w_load_data = {{16{w_half[15]}}, w_half};
      5'b10000: w_load_data = {16'd0, w_half};
      default:  w_load_data = '0;
    endcase
  end

  assign bus.in_allow_in    = w_allow_in;
  assign bus.out_valid      = r_valid;
  assign bus.out_ex         = r_ex;
  assign bus.out_pc         = r_pc;
  assign bus.out_dest       = r_dest;
  assign bus.out_ctrl_info  = r_ctrl;
  assign bus.out_ctrl_info2 = r_ctrl2;
  assign bus.wb_value       = (w_load_op && (r_ex == 6'd0)) ? w_load_data : r_mem_value;
  assign bus.data_finish    = r_valid && w_reg_we;
endmodule

// File: tb/tb_load_resp_stage.sv
// Bench for load_resp_stage: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an instruction-level model of the stage.
module tb_load_resp_stage;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  load_resp_stage_if bus ();

  load_resp_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: one held instruction and the RAM word seen on its first occupancy cycle.
  bit          m_valid;
  bit          m_first;
  logic [31:0] m_word;
  logic [5:0]  m_ex;
  logic [31:0] m_pc, m_ctrl, m_ctrl2, m_mem;
  logic [4:0]  m_dest;
  logic [1:0]  m_off;

  function automatic logic [31:0] exp_wb(input logic [31:0] ctrl, input logic [5:0] ex,
                                         input logic [31:0] mem, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    if (ctrl[11] == 1'b0 || ex != 6'd0) return mem;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * off[1])) & 32'hFFFF;
    case (ctrl[10:6])
      5'b00001: return word;
      5'b00010: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      5'b00100: return b;
      5'b01000: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      5'b10000: return h;
      default:  return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    bit allow;
    if (!resetn) begin
      m_valid = 1'b0;
      m_first = 1'b0;
    end else begin
      allow = !m_valid || bus.out_allow;
      if (m_valid && m_first) m_word = bus.data_ram_dout;
      m_first = 1'b0;
      if (allow) begin
        if (bus.in_valid) begin
          m_valid = 1'b1;
          m_first = 1'b1;
          m_ex    = bus.in_ex;
          m_pc    = bus.in_pc;
          m_ctrl  = bus.in_ctrl_info;
          m_ctrl2 = bus.in_ctrl_info2;
          m_dest  = bus.in_dest;
          m_mem   = bus.in_mem_value;
          m_off   = bus.in_offset;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_allow_in", {31'd0, bus.in_allow_in}, 32'd1);
      chk("rst_wb_value", bus.wb_value, 32'd0);
      chk("rst_data_finish", {31'd0, bus.data_finish}, 32'd0);
    end else begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      chk("in_allow_in", {31'd0, bus.in_allow_in}, {31'd0, (!m_valid || bus.out_allow)});
      if (m_valid) begin
        chk("out_pc", bus.out_pc, m_pc);
        chk("out_ex", {26'd0, bus.out_ex}, {26'd0, m_ex});
        chk("out_dest", {27'd0, bus.out_dest}, {27'd0, m_dest});
        chk("out_ctrl_info", bus.out_ctrl_info, m_ctrl);
        chk("out_ctrl_info2", bus.out_ctrl_info2, m_ctrl2);
        chk("wb_value", bus.wb_value,
            exp_wb(m_ctrl, m_ex, m_mem, m_off, m_first ? bus.data_ram_dout : m_word));
        chk("data_finish", {31'd0, bus.data_finish}, {31'd0, m_ctrl[27]});
      end
    end
  end

  function automatic logic [31:0] mk_ctrl(input bit we, input bit lop, input logic [4:0] lt);
    logic [31:0] c;
    c       = $urandom;
    c[27]   = we;
    c[11]   = lop;
    c[10:6] = lt;
    return c;
  endfunction

  task automatic set_in(input bit v, input logic [31:0] ctrl, input logic [5:0] ex,
                        input logic [31:0] pc, input logic [31:0] mem, input logic [1:0] off);
    bus.in_valid      = v;
    bus.in_ctrl_info  = ctrl;
    bus.in_ex         = ex;
    bus.in_pc         = pc;
    bus.in_mem_value  = mem;
    bus.in_offset     = off;
    bus.in_ctrl_info2 = $urandom;
    bus.in_dest       = 5'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] LT_LW = 5'b00001, LT_LB = 5'b00010, LT_LBU = 5'b00100,
                         LT_LH = 5'b01000, LT_LHU = 5'b10000;

  initial begin
    logic [4:0] lt;
    logic [5:0] ex;
    n_cmp  = 0;
    n_bad  = 0;
    resetn = 1'b0;
    set_in(1'b0, 32'd0, 6'd0, 32'd0, 32'd0, 2'd0);
    bus.out_allow     = 1'b1;
    bus.data_ram_dout = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_allow_literal", {31'd0, bus.in_allow_in}, 32'd1);
    chk("reset_valid_literal", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // LW offset 0
    set_in(1'b1, mk_ctrl(1'b1, 1'b1, LT_LW), 6'd0, 32'h40, 32'd0, 2'd0);
    step();
    set_in(1'b1, mk_ctrl(1'b1, 1'b1, LT_LB), 6'd0, 32'h44, 32'd0, 2'd3);
    bus.data_ram_dout = 32'h8000_00F1;
    @(negedge clk);
    chk("lw_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lw_wb", bus.wb_value, 32'h8000_00F1);
    chk("lw_finish", {31'd0, bus.data_finish}, 32'd1);

    // LB then LBU, offset 3
    step();
    set_in(1'b1, mk_ctrl(1'b1, 1'b1, LT_LBU), 6'd0, 32'h48, 32'd0, 2'd3);
    bus.data_ram_dout = 32'h80FF_0011;
    @(negedge clk);
    chk("lb_wb", bus.wb_value, 32'hFFFF_FF80);
    step();
    set_in(1'b1, mk_ctrl(1'b0, 1'b1, LT_LH), 6'd0, 32'h4C, 32'd0, 2'd2);
    @(negedge clk);
    chk("lbu_wb", bus.wb_value, 32'h0000_0080);

    // LH offset 2 stalled with the RAM output changing underneath
    step();
    set_in(1'b0, 32'd0, 6'd0, 32'd0, 32'd0, 2'd0);
    bus.data_ram_dout = 32'h9234_5678;
    bus.out_allow     = 1'b0;
    @(negedge clk);
    chk("lh_wb_first", bus.wb_value, 32'hFFFF_9234);
    chk("lh_allow_first", {31'd0, bus.in_allow_in}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      bus.data_ram_dout = 32'd0;
      @(negedge clk);
      chk("lh_wb_stall", bus.wb_value, 32'hFFFF_9234);
      chk("lh_allow_stall", {31'd0, bus.in_allow_in}, 32'd0);
    end
    step();
    bus.out_allow = 1'b1;
    @(negedge clk);
    chk("lh_wb_release", bus.wb_value, 32'hFFFF_9234);
    chk("lh_allow_release", {31'd0, bus.in_allow_in}, 32'd1);

    // Non-load forwards mem_value; faulting load forwards mem_value too
    step();
    set_in(1'b1, mk_ctrl(1'b1, 1'b0, 5'd0), 6'd0, 32'h50, 32'h1234, 2'd0);
    step();
    set_in(1'b1, mk_ctrl(1'b1, 1'b1, LT_LW), 6'h20, 32'h54, 32'hABCD, 2'd0);
    bus.data_ram_dout = $urandom;
    @(negedge clk);
    chk("nonload_wb", bus.wb_value, 32'h1234);
    step();
    set_in(1'b0, 32'd0, 6'd0, 32'd0, 32'd0, 2'd0);
    bus.data_ram_dout = $urandom;
    @(negedge clk);
    chk("fault_wb", bus.wb_value, 32'hABCD);
    chk("fault_ex", {26'd0, bus.out_ex}, 32'h20);

    // Back-to-back with no bubble
    for (int i = 0; i < 4; i++) begin
      step();
      set_in(1'b1, mk_ctrl(1'b1, 1'b0, 5'd0), 6'd0, 32'h100 + 32'(4 * i), 32'd0, 2'd0);
      if (i > 0) begin
        @(negedge clk);
        chk("b2b_pc", bus.out_pc, 32'h100 + 32'(4 * (i - 1)));
        chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
      end
    end
    step();
    set_in(1'b0, 32'd0, 6'd0, 32'd0, 32'd0, 2'd0);
    @(negedge clk);
    chk("b2b_pc_last", bus.out_pc, 32'h10C);

    // Reset during a stall
    step();
    set_in(1'b1, mk_ctrl(1'b1, 1'b1, LT_LW), 6'd0, 32'h200, 32'd0, 2'd0);
    step();
    set_in(1'b0, 32'd0, 6'd0, 32'd0, 32'd0, 2'd0);
    bus.out_allow = 1'b0;
    @(negedge clk);
    chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_finish", {31'd0, bus.data_finish}, 32'd0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_allow", {31'd0, bus.in_allow_in}, 32'd1);
    chk("postrst_valid", {31'd0, bus.out_valid}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      ex = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      case ($urandom_range(0, 4))
        0: lt = LT_LW;
        1: lt = LT_LB;
        2: lt = LT_LBU;
        3: lt = LT_LH;
        default: lt = LT_LHU;
      endcase
      if (ex == 6'd0 && $urandom_range(0, 9) == 0) lt = 5'($urandom);
      set_in($urandom_range(0, 9) < 7, mk_ctrl(1'($urandom), 1'($urandom), lt), ex,
             $urandom, $urandom, 2'($urandom));
      bus.out_allow     = $urandom_range(0, 9) < 6;
      bus.data_ram_dout = $urandom;
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_resp_stage.md
LOAD_RESP_STAGE -- requirements
Module: load_resp_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and resetn.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  execute stage holds a valid instruction for this stage.
REQ-006 in_allow_in  out  1  this stage accepts a new instruction this cycle.
REQ-007 in_ex  in  6  exception flags from execute; nonzero means the instruction faulted.
REQ-008 in_pc / in_ctrl_info / in_ctrl_info2  in  32 each  PC and control words, passed through.
REQ-009 in_dest  in  5  destination register number.
REQ-010 in_mem_value  in  32  ALU/move result from execute.
REQ-011 in_offset  in  2  byte offset of the data address (address bits [1:0]).
REQ-012 data_ram_dout  in  32  synchronous data RAM read data; valid the cycle after the address was presented.
REQ-013 out_allow  in  1  writeback stage accepts.
REQ-014 out_valid  out  1  this stage holds a completed instruction.
REQ-015 out_ex / out_pc / out_dest / out_ctrl_info / out_ctrl_info2  out  6/32/5/32/32  registered copies of the inputs.
REQ-016 wb_value  out  32  final register write value.
REQ-017 data_finish  out  1  wb_value is final and usable for bypass.

Function
REQ-018 Control fields SHALL be decoded from the held ctrl_info: reg_we = bit 27; load_op = bit 11; load_type = bits [10:6], one-hot [0]LW, [1]LB, [2]LBU, [3]LH, [4]LHU.
REQ-019 in_allow_in SHALL equal !stage_valid || out_allow; the stage always completes in one cycle.
REQ-020 When in_valid && in_allow_in, the stage SHALL capture all in_* fields on the clock edge and set stage_valid.
REQ-021 When in_allow_in is high and in_valid is low, the stage SHALL clear stage_valid on the clock edge.
REQ-022 out_valid SHALL equal stage_valid.
REQ-023 Read-data hold, occupancy cycle: on the first occupancy cycle of an instruction, the block SHALL use data_ram_dout directly.
REQ-024 Read-data hold, stall: if out_allow is low on the first occupancy cycle, the block SHALL latch data_ram_dout into dout_hold and set hold_vld.
REQ-025 Read-data hold, later cycles: while hold_vld is set, the block SHALL use dout_hold.
REQ-026 Read-data hold, clear: hold_vld SHALL clear whenever a new instruction is captured or the stage empties.
REQ-027 Load extraction, LW: result = the word.
REQ-028 Load extraction, LB/LBU: result = the byte at offset*8, sign- or zero-extended to 32 bits.
REQ-029 Load extraction, LH/LHU: result = the halfword at offset[1]*16, sign- or zero-extended to 32 bits.
REQ-030 wb_value SHALL be the extracted load data when load_op is set and out_ex is 0; otherwise it SHALL be the held mem_value.
REQ-031 If load_type is not exactly one-hot while load_op is set, wb_value SHALL be 0.
REQ-032 data_finish SHALL equal stage_valid && reg_we.
REQ-033 Simultaneous drain and fill (stage_valid, out_allow, in_valid all 1): the new instruction SHALL replace the old one on the same edge with no bubble.

Reset
REQ-034 While resetn is low, stage_valid, hold_vld, dout_hold and all held fields SHALL be 0.
REQ-035 At reset, out_valid=0, data_finish=0, wb_value=0 and in_allow_in=1.
REQ-036 Reset asserted mid-stall SHALL discard the held instruction with no output pulse.

Verification
REQ-037 Scenario: LW, offset=0, dout=0x8000_00F1, out_allow=1 -> next cycle out_valid=1, wb_value=0x8000_00F1, data_finish=1.
REQ-038 Scenario: LB, offset=3, dout=0x80FF_0011 -> wb_value=0xFFFF_FF80; LBU with the same inputs -> wb_value=0x0000_0080.
REQ-039 Scenario: LH, offset=2, dout=0x9234_5678, out_allow=0 for 3 cycles while dout changes to 0 -> wb_value=0xFFFF_9234 every cycle; in_allow_in=0 until out_allow rises.
REQ-040 Scenario: non-load with mem_value=0x1234, in_ex=6'h20 on a load -> wb_value=0x1234 for the non-load; mem_value is forwarded for the faulting load.
REQ-041 Scenario: back-to-back valid instructions with out_allow=1 -> one instruction per cycle, out_pc sequence matches the input order, no bubble.
REQ-042 Scenario: resetn low during a stall -> out_valid=0 immediately; after release, in_allow_in=1.
